player_ctrl: RTL and testbench
==============================

PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter BOARD_N, default 15: board edge length in cells; legal range 5..31.
REQ-002 Parameter COORD_W, default 4: coordinate width; SHALL equal $clog2(BOARD_N).
REQ-003 Parameter WRAP, default 1: 1 = cursor wraps at edges, 0 = cursor clamps at edges.
REQ-004 Parameter TIMEOUT_CYC, default 50000: idle clk cycles after which a partial PS/2 frame is abandoned.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ps2_clk  in  1  raw PS/2 clock, asynchronous.
REQ-008 ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-009 is_player  in  1  high while it is the human player's turn.
REQ-010 have_chess  in  1  high when the cell at (choose_row, choose_col) is occupied.
REQ-011 disp  out  BOARD_N*BOARD_N  one-hot cursor map; bit index = row*BOARD_N + col.
REQ-012 choose_row  out  COORD_W  cursor row, registered.
REQ-013 choose_col  out  COORD_W  cursor column, registered.
REQ-014 pressed  out  1  one-cycle placement strobe for the current cursor cell.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-FF synchroniser; bits sample on the synchronised ps2_clk falling edge.
REQ-016 Frame: start 0, 8 data bits LSB first, odd parity, stop 1; a frame with a bad start, parity or stop bit SHALL be discarded silently.
REQ-017 TIMEOUT_CYC cycles with no falling edge mid-frame SHALL reset the bit counter to 0.
REQ-018 A valid frame SHALL produce a one-cycle byte_valid with its 8-bit code.
REQ-019 Decoder FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0).
REQ-020 Transitions: IDLE--F0-->BRK, IDLE--E0-->EXT, EXT--F0-->EXT_BRK; any other byte in BRK/EXT/EXT_BRK returns to IDLE after the action below.
REQ-021 Make codes in IDLE: 0x1D up, 0x1B down, 0x1C left, 0x23 right, 0x5A enter; all others ignored.
REQ-022 Any byte received in BRK or EXT_BRK SHALL be ignored (break code).
REQ-023 Up = row-1, down = row+1, left = col-1, right = col+1.
REQ-024 WRAP=1: 0-1 -> BOARD_N-1 and BOARD_N-1+1 -> 0; WRAP=0: the coordinate holds at 0 / BOARD_N-1.
REQ-025 Moves SHALL apply regardless of is_player.
REQ-026 Enter SHALL assert pressed for exactly one cycle iff is_player=1 and have_chess=0 in the decode cycle; otherwise it is dropped without being queued.
REQ-027 Cursor, disp and pressed SHALL update on the clk edge after the byte_valid cycle (1-cycle latency).
REQ-028 disp SHALL be derived from the registered cursor and update in the same cycle as choose_row/choose_col.
REQ-029 When is_player falls, the decoder FSM state SHALL be kept; only enter gating changes.

Reset
REQ-030 rst SHALL set choose_row = choose_col = (BOARD_N-1)/2, disp to one-hot at that cell, pressed = 0, FSM = IDLE, and clear the PS/2 bit counter and timeout counter.
REQ-031 rst asserted mid-frame SHALL abandon the frame; the next frame after rst deasserts SHALL decode normally.

Configuration
REQ-032 Macro PLAYER_CTRL_ARROW_EN defined: in EXT state, 0x75 up, 0x72 down, 0x6B left, 0x74 right, with the same move rules.
REQ-033 Macro PLAYER_CTRL_ARROW_EN undefined: the byte following 0xE0 (and any E0 F0 xx sequence) SHALL be consumed and ignored.

Structure
REQ-034 Package player_pkg SHALL hold the scan-code constants, the decoder state enum and the reset-centre function.
REQ-035 Sub-module ps2_rx SHALL hold synchronisers, frame shift, parity/timeout checks and byte_valid; player_ctrl holds the decoder and cursor.

Verification
REQ-036 Reset, BOARD_N=15 -> row=7, col=7, disp bit 112 only, pressed=0.
REQ-037 WRAP=1: 8 "up" frames (0x1D) from reset -> row 7..0 then 14; byte F0 1D -> no move.
REQ-038 WRAP=0, BOARD_N=9: 6 "right" frames from reset -> col 4..8, then holds at 8.
REQ-039 0x5A with is_player=1, have_chess=0 -> one-cycle pressed pulse; with have_chess=1 or is_player=0 -> no pulse.
REQ-040 Frame 0x1C with a bad parity bit -> no move; 5 bits then TIMEOUT_CYC idle cycles, then a valid 0x23 -> col+1.
REQ-041 E0 75: with PLAYER_CTRL_ARROW_EN -> row-1; without it -> no change, and the next plain 0x1D -> row-1.

Source files
------------

// File: rtl/player_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Shared definitions for the keyboard-driven cursor controller:
//   - PS/2 set-2 scan-code constants (make codes, break/extended prefixes)
//   - decoder state enum
//   - reset_centre(): the cursor cell a reset returns to
// ---------------------------------------------------------------------------
package player_pkg;

  // Plain make codes (W/S/A/D-style keys and Enter)
  localparam logic [7:0] SC_UP       = 8'h1D;
  localparam logic [7:0] SC_DOWN     = 8'h1B;
  localparam logic [7:0] SC_LEFT     = 8'h1C;
  localparam logic [7:0] SC_RIGHT    = 8'h23;
  localparam logic [7:0] SC_ENTER    = 8'h5A;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_AR_UP    = 8'h75;
  localparam logic [7:0] SC_AR_DOWN  = 8'h72;
  localparam logic [7:0] SC_AR_LEFT  = 8'h6B;
  localparam logic [7:0] SC_AR_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

  // Centre cell of a board_n x board_n board (rounded down for even sizes)
  function automatic int reset_centre(input int board_n);
    return (board_n - 1) / 2;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver. Both raw PS/2 lines are brought into the
// clk domain through 2-FF synchronisers; one bit is taken per falling edge of
// the synchronised PS/2 clock. A frame is start(0), 8 data bits LSB first,
// odd parity, stop(1). Frames with a bad start/parity/stop bit are dropped
// without any indication. A frame that stalls for TIMEOUT_CYC clk cycles is
// abandoned so the next start bit realigns the receiver.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   i_ps2_clk    in   raw PS/2 clock (asynchronous)
//   i_ps2_data   in   raw PS/2 data  (asynchronous)
//   o_byte_valid out  one-cycle strobe, o_byte holds a good received code
//   o_byte       out  received 8-bit code
// ---------------------------------------------------------------------------
module ps2_rx #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic            r_clk_prev;
  logic [3:0]      r_bitcnt;
  logic [9:0]      r_shift;
  logic [TO_W-1:0] r_tocnt;
  logic            r_byte_valid;
  logic [7:0]      r_byte;

  logic            w_fall;
  logic [10:0]     w_frame;
  logic            w_frame_ok;

  assign w_fall = r_clk_prev & ~r_clk_sync[1];

  // r_shift holds bits 0..9 (start, data, parity); the stop bit is the
  // synchronised data line at the 11th falling edge.
  assign w_frame    = {r_dat_sync[1], r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  // Synchronisers, bit counter and timeout (control)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_clk_prev   <= 1'b1;
      r_bitcnt     <= '0;
      r_tocnt      <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev   <= r_clk_sync[1];
      r_byte_valid <= 1'b0;
      if (w_fall) begin
        r_tocnt <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt     <= '0;
          r_byte_valid <= w_frame_ok;
        end else begin
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        // Only a frame in progress can time out
        if (r_tocnt == TO_LAST) begin
          r_bitcnt <= '0;
          r_tocnt  <= '0;
        end else begin
          r_tocnt <= r_tocnt + 1'b1;
        end
      end
    end
  end

  // Frame shift and captured byte (data path, no reset)
  always_ff @(posedge clk) begin
    if (w_fall) begin
      if (r_bitcnt == 4'd10) begin
        r_byte <= w_frame[8:1];
      end else begin
        r_shift <= {r_dat_sync[1], r_shift[9:1]};
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte       = r_byte;

endmodule

// File: rtl/player_ctrl.sv
// ---------------------------------------------------------------------------
// player_ctrl
// Keyboard cursor controller for a BOARD_N x BOARD_N board game. PS/2 codes
// from ps2_rx are decoded (make / break / extended prefixes) into cursor
// moves and a placement strobe.
//
// Build option
//   PLAYER_CTRL_ARROW_EN  defined: E0-prefixed arrow keys also move the
//                         cursor. Undefined: the byte after E0 is swallowed.
//
// Parameters
//   BOARD_N      board edge in cells (5..31)
//   COORD_W      coordinate width, must equal $clog2(BOARD_N)
//   WRAP         1 = cursor wraps at the edges, 0 = clamps
//   TIMEOUT_CYC  idle clk cycles before a partial PS/2 frame is dropped
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   ps2_clk     in   raw PS/2 clock (asynchronous)
//   ps2_data    in   raw PS/2 data  (asynchronous)
//   is_player   in   high during the human player's turn
//   have_chess  in   high when the cursor cell is occupied
//   disp        out  one-hot cursor map, bit row*BOARD_N+col
//   choose_row  out  cursor row (registered)
//   choose_col  out  cursor column (registered)
//   pressed     out  one-cycle placement strobe
// ---------------------------------------------------------------------------
module player_ctrl
  import player_pkg::*;
#(
  parameter int BOARD_N     = 15,
  parameter int COORD_W     = 4,
  parameter int WRAP        = 1,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       is_player,
  input  logic                       have_chess,
  output logic [BOARD_N*BOARD_N-1:0] disp,
  output logic [COORD_W-1:0]         choose_row,
  output logic [COORD_W-1:0]         choose_col,
  output logic                       pressed
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [COORD_W-1:0] C_MAX    = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] C_CENTRE = COORD_W'(reset_centre(BOARD_N));

  // Step a coordinate down / up, wrapping or saturating at the board edge
  function automatic logic [COORD_W-1:0] step_dec(input logic [COORD_W-1:0] c);
    if (c == '0) return (WRAP != 0) ? C_MAX : '0;
    return c - 1'b1;
  endfunction

  function automatic logic [COORD_W-1:0] step_inc(input logic [COORD_W-1:0] c);
    if (c == C_MAX) return (WRAP != 0) ? '0 : C_MAX;
    return c + 1'b1;
  endfunction

  logic             w_byte_valid;
  logic [7:0]       w_byte;

  dec_state_t       r_state;
  dec_state_t       w_state_nxt;
  logic             w_up;
  logic             w_down;
  logic             w_left;
  logic             w_right;
  logic             w_enter;

  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               r_pressed;
  logic [IDX_W-1:0]   w_idx;
  logic [CELLS-1:0]   w_disp;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ps2_rx (
    .clk          (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte)
  );

  // Stage p0: decode the received byte into a next state and one action
  always_comb begin
    w_state_nxt = r_state;
    w_up        = 1'b0;
    w_down      = 1'b0;
    w_left      = 1'b0;
    w_right     = 1'b0;
    w_enter     = 1'b0;
    if (w_byte_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          case (w_byte)
            SC_BREAK: w_state_nxt = ST_BRK;
            SC_EXT:   w_state_nxt = ST_EXT;
            SC_UP:    w_up        = 1'b1;
            SC_DOWN:  w_down      = 1'b1;
            SC_LEFT:  w_left      = 1'b1;
            SC_RIGHT: w_right     = 1'b1;
            SC_ENTER: w_enter     = 1'b1;
            default:  ;
          endcase
        end
        // Byte after F0 is the released key: swallow it
        ST_BRK: w_state_nxt = ST_IDLE;
        ST_EXT: begin
          if (w_byte == SC_BREAK) begin
            w_state_nxt = ST_EXT_BRK;
          end else begin
            w_state_nxt = ST_IDLE;
`ifdef PLAYER_CTRL_ARROW_EN
            case (w_byte)
              SC_AR_UP:    w_up    = 1'b1;
              SC_AR_DOWN:  w_down  = 1'b1;
              SC_AR_LEFT:  w_left  = 1'b1;
              SC_AR_RIGHT: w_right = 1'b1;
              default:     ;
            endcase
`endif
          end
        end
        ST_EXT_BRK: w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p1: decoder state, cursor and placement strobe registers.
  // The decoder keeps its state across turn changes; is_player only gates
  // the enter strobe, and a gated enter is dropped rather than held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_row     <= C_CENTRE;
      r_col     <= C_CENTRE;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pressed <= w_enter & is_player & ~have_chess;
      if (w_up)    r_row <= step_dec(r_row);
      if (w_down)  r_row <= step_inc(r_row);
      if (w_left)  r_col <= step_dec(r_col);
      if (w_right) r_col <= step_inc(r_col);
    end
  end

  // One-hot map taken straight from the cursor registers so it moves in the
  // same cycle as choose_row/choose_col.
  assign w_idx = IDX_W'(r_row) * IDX_W'(BOARD_N) + IDX_W'(r_col);

  always_comb begin
    w_disp = '0;
    for (int i = 0; i < CELLS; i++) begin
      w_disp[i] = (w_idx == IDX_W'(i));
    end
  end

  assign disp       = w_disp;
  assign choose_row = r_row;
  assign choose_col = r_col;
  assign pressed    = r_pressed;

endmodule

// File: tb/tb_player_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_ctrl
// Two instances: u_a (15x15, wrapping) and u_b (9x9, clamping), each with its
// own PS/2 lines. A table of frames with hand-computed cursor/strobe results
// is applied in order, followed by sequences for timeout, latency and reset
// in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_player_ctrl;

  localparam int TO   = 100;
  localparam int HALF = 8;
`ifdef PLAYER_CTRL_ARROW_EN
  localparam bit ARROW = 1'b1;
`else
  localparam bit ARROW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pc_a = 1'b1, pd_a = 1'b1, pc_b = 1'b1, pd_b = 1'b1;
  logic         ip = 1'b1, hc = 1'b0;
  logic [224:0] disp_a;
  logic [80:0]  disp_b;
  logic [3:0]   row_a, col_a, row_b, col_b;
  logic         prs_a, prs_b;

  int n_checks = 0;
  int n_err    = 0;
  int pcnt_a   = 0;
  int pcnt_b   = 0;

  player_ctrl #(.BOARD_N(15), .COORD_W(4), .WRAP(1), .TIMEOUT_CYC(TO)) u_a (
    .clk(clk), .rst(rst), .ps2_clk(pc_a), .ps2_data(pd_a),
    .is_player(ip), .have_chess(hc), .disp(disp_a),
    .choose_row(row_a), .choose_col(col_a), .pressed(prs_a));

  player_ctrl #(.BOARD_N(9), .COORD_W(4), .WRAP(0), .TIMEOUT_CYC(TO)) u_b (
    .clk(clk), .rst(rst), .ps2_clk(pc_b), .ps2_data(pd_b),
    .is_player(ip), .have_chess(hc), .disp(disp_b),
    .choose_row(row_b), .choose_col(col_b), .pressed(prs_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prs_a) pcnt_a <= pcnt_a + 1;
    if (prs_b) pcnt_b <= pcnt_b + 1;
  end

  typedef struct {
    bit         tgt;    // 0 = u_a, 1 = u_b
    logic [7:0] code;
    bit         bad;    // flip parity bit
    bit         ipl;
    bit         hch;
    int         row;
    int         col;
    int         prs;    // expected strobe cycles for this frame
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit t, logic [7:0] c, bit b, bit i, bit h,
                              int r, int cl, int p);
    vec_t v;
    v.tgt = t; v.code = c; v.bad = b; v.ipl = i; v.hch = h;
    v.row = r; v.col = cl; v.prs = p;
    return v;
  endfunction

  function automatic logic [255:0] onehot(input int idx);
    logic [255:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input bit t, input bit is_clk, input logic v);
    if (t) begin
      if (is_clk) pc_b = v; else pd_b = v;
    end else begin
      if (is_clk) pc_a = v; else pd_a = v;
    end
  endtask

  // Shift out the first nbits of a frame; data changes while PS/2 clk is high
  task automatic send_bits(input bit t, input logic [7:0] code, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      set_line(t, 1'b0, f[i]);
      repeat (HALF) @(negedge clk);
      set_line(t, 1'b1, 1'b0);
      repeat (HALF) @(negedge clk);
      set_line(t, 1'b1, 1'b1);
    end
    set_line(t, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input bit t, input logic [7:0] code, input bit bad);
    send_bits(t, code, bad, 11);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int r_end;
    int pa, pb;
    bit found;

    // -------- table: state carries from one row to the next --------
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 8'h1D, 0, 1, 0, (k < 7) ? 6 - k : 14, 7, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 1, 0, 14, 7, 0));
    vecs.push_back(mk(0, 8'h1D, 0, 1, 0, 14, 7, 0));   // break code: no move
    vecs.push_back(mk(0, 8'h1D, 0, 1, 0, 13, 7, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 8'h23, 0, 1, 0, 4, (k < 4) ? 5 + k : 8, 0));
    vecs.push_back(mk(0, 8'h5A, 0, 1, 0, 13, 7, 1));
    vecs.push_back(mk(0, 8'h5A, 0, 1, 1, 13, 7, 0));
    vecs.push_back(mk(0, 8'h5A, 0, 0, 0, 13, 7, 0));
    vecs.push_back(mk(0, 8'h1C, 1, 1, 0, 13, 7, 0));   // bad parity
    vecs.push_back(mk(0, 8'h1C, 0, 1, 0, 13, 6, 0));
    vecs.push_back(mk(0, 8'h1B, 0, 1, 0, 14, 6, 0));
    vecs.push_back(mk(0, 8'h1B, 0, 1, 0, 0, 6, 0));    // wrap bottom -> top
    vecs.push_back(mk(0, 8'hE0, 0, 1, 0, 0, 6, 0));
    vecs.push_back(mk(0, 8'h75, 0, 1, 0, ARROW ? 14 : 0, 6, 0));
    vecs.push_back(mk(0, 8'h1D, 0, 1, 0, ARROW ? 13 : 14, 6, 0));
    vecs.push_back(mk(0, 8'hE0, 0, 1, 0, ARROW ? 13 : 14, 6, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 1, 0, ARROW ? 13 : 14, 6, 0));
    vecs.push_back(mk(0, 8'h75, 0, 1, 0, ARROW ? 13 : 14, 6, 0));
    vecs.push_back(mk(0, 8'h1D, 0, 1, 0, ARROW ? 12 : 13, 6, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 1, 0, ARROW ? 12 : 13, 6, 0));
    vecs.push_back(mk(0, 8'h5A, 0, 1, 0, ARROW ? 12 : 13, 6, 0)); // released enter
    vecs.push_back(mk(0, 8'h5A, 0, 1, 0, ARROW ? 12 : 13, 6, 1));
    r_end = ARROW ? 12 : 13;

    // -------- reset state --------
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_row_a", row_a, 7);
    chk("rst_col_a", col_a, 7);
    chk("rst_disp_a", disp_a, onehot(112));
    chk("rst_prs_a", prs_a, 0);
    chk("rst_row_b", row_b, 4);
    chk("rst_col_b", col_b, 4);
    chk("rst_disp_b", disp_b, onehot(40));

    // -------- table --------
    foreach (vecs[k]) begin
      ip = vecs[k].ipl;
      hc = vecs[k].hch;
      pa = pcnt_a;
      pb = pcnt_b;
      send_frame(vecs[k].tgt, vecs[k].code, vecs[k].bad);
      if (vecs[k].tgt) begin
        chk($sformatf("v%0d_row_b", k), row_b, vecs[k].row);
        chk($sformatf("v%0d_col_b", k), col_b, vecs[k].col);
        chk($sformatf("v%0d_disp_b", k), disp_b, onehot(vecs[k].row * 9 + vecs[k].col));
        chk($sformatf("v%0d_prs_b", k), pcnt_b - pb, vecs[k].prs);
      end else begin
        chk($sformatf("v%0d_row_a", k), row_a, vecs[k].row);
        chk($sformatf("v%0d_col_a", k), col_a, vecs[k].col);
        chk($sformatf("v%0d_disp_a", k), disp_a, onehot(vecs[k].row * 15 + vecs[k].col));
        chk($sformatf("v%0d_prs_a", k), pcnt_a - pa, vecs[k].prs);
      end
    end
    ip = 1'b1;
    hc = 1'b0;

    // -------- partial frame abandoned by timeout --------
    send_bits(0, 8'h1C, 0, 5);
    repeat (TO + 40) @(negedge clk);
    chk("to_partial_col", col_a, 6);
    send_frame(0, 8'h23, 0);
    chk("to_after_col", col_a, 7);
    chk("to_after_row", row_a, r_end);

    // -------- one-cycle latency from byte_valid to cursor --------
    found = 1'b0;
    fork
      send_bits(0, 8'h1C, 0, 11);
      begin
        for (int c = 0; c < 400 && !found; c++) begin
          @(posedge clk);
          #1;
          if (u_a.w_byte_valid) found = 1'b1;
        end
        if (found) begin
          chk("lat_before", col_a, 7);
          @(posedge clk);
          #1;
          chk("lat_after", col_a, 6);
          chk("lat_disp", disp_a, onehot(r_end * 15 + 6));
        end
      end
    join
    chk("lat_seen", found, 1);
    repeat (20) @(negedge clk);

    // -------- reset in the middle of a frame --------
    send_bits(1, 8'h23, 0, 5);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_row_a", row_a, 7);
    chk("mrst_col_a", col_a, 7);
    chk("mrst_col_b", col_b, 4);
    chk("mrst_disp_a", disp_a, onehot(112));
    send_frame(1, 8'h23, 0);
    chk("mrst_next_col_b", col_b, 5);
    chk("mrst_next_row_b", row_b, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
